hs_ram_arbiter: RTL and testbench

Arbitrates the game's shared work-RAM port between the main CPU and the hiscore save/restore engine. The arbiter requests a CPU pause, waits for the pause acknowledge, lets the bus settle, and only then grants the RAM port to the hiscore engine. When the engine's intent drops, the arbiter releases the pause. It sits between the game core's work-RAM interface, the hiscore module and the pause module, all clocked from the 49 MHz system clock.

---
 rtl/hs_ram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_ram_arbiter.sv
// -----------------------------------------------------------------------------
// hs_ram_arbiter
//
// Shares the game's work-RAM port between the main CPU and the hiscore
// save/restore engine. When the engine signals intent, the arbiter asks the
// pause module to halt the CPU, waits for the acknowledge, lets the bus settle
// for SETTLE_CYCLES clocks and only then hands the RAM port to the engine.
// Dropping intent (or losing the acknowledge) releases the port and the pause.
//
// Ports:
//   clk_49m, reset        system clock, asynchronous active-high reset
//   cpu_addr/din/we       CPU side of the RAM port, cpu_dout = RAM read data
//   hs_addr/din/we        hiscore side of the RAM port
//   hs_intent_read/write  hiscore engine wants the RAM port
//   hs_dout               registered read data for the hiscore engine
//   hs_grant              hiscore engine currently owns the RAM port
//   pause_req/pause_ack   handshake with the pause module
//   ram_addr/din/we/dout  shared RAM port
//   blocked_wr            sticky: a CPU write was dropped during a grant
//   timeout_err           (HS_ARB_TIMEOUT_EN only) 1-cycle pulse when the
//                         pause acknowledge never arrived
//
// Optional build macro: HS_ARB_TIMEOUT_EN adds a bounded wait in REQ and the
// timeout_err output. Without it REQ waits indefinitely.
// -----------------------------------------------------------------------------
module hs_ram_arbiter #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 8,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic              clk_49m,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_we,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic [ADDR_W-1:0] hs_addr,
    input  logic [DATA_W-1:0] hs_din,
    input  logic              hs_we,
    input  logic              hs_intent_read,
    input  logic              hs_intent_write,
    output logic [DATA_W-1:0] hs_dout,
    output logic              hs_grant,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
`ifdef HS_ARB_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              blocked_wr
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
        $error("hs_ram_arbiter: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETTLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        settle_q, settle_d;
    logic              grant_prev_q;
    logic [DATA_W-1:0] hs_dout_q;
    logic              blocked_q;
    logic              intent;

`ifdef HS_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_err_q;
    logic        tmo_hit;
`endif

    assign intent = hs_intent_read | hs_intent_write;

    // Next-state logic. Losing pause_ack after it was granted is treated as a
    // protocol error and handled exactly like a dropped intent.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
`ifdef HS_ARB_TIMEOUT_EN
        tmo_d    = '0;
        tmo_hit  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (intent) state_d = REQ;
            end
            REQ: begin
                if (!intent) begin
                    state_d = RELEASE;
                end else if (pause_ack) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
`ifdef HS_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = RELEASE;
                    tmo_hit = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            SETTLE: begin
                if (!intent || !pause_ack) begin
                    state_d = RELEASE;
                end else if (settle_q == 8'd0) begin
                    state_d = GRANT;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            GRANT: begin
                if (!intent || !pause_ack) state_d = RELEASE;
            end
            RELEASE: begin
                // Always wait for the CPU to resume before a new request.
                if (!pause_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            settle_q     <= '0;
            grant_prev_q <= 1'b0;
            hs_dout_q    <= '0;
            blocked_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            grant_prev_q <= hs_grant;
            // RAM data is one cycle behind the address, so capture when the
            // address of the previous cycle came from the hiscore engine.
            if (grant_prev_q) hs_dout_q <= ram_dout;
            if (cpu_we && hs_grant) blocked_q <= 1'b1;
        end
    end

`ifdef HS_ARB_TIMEOUT_EN
    always_ff @(posedge clk_49m or posedge reset) begin
        if (reset) begin
            tmo_q     <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tmo_err_q <= tmo_hit;
        end
    end

    assign timeout_err = tmo_err_q;
`endif

    // Grant and pause are decoded from the state register, so an asynchronous
    // reset returns the mux to the CPU without waiting for a clock edge.
    assign hs_grant  = (state_q == GRANT);
    assign pause_req = (state_q == REQ) || (state_q == SETTLE) || (state_q == GRANT);

    assign ram_addr   = hs_grant ? hs_addr : cpu_addr;
    assign ram_din    = hs_grant ? hs_din  : cpu_din;
    assign ram_we     = hs_grant ? hs_we   : cpu_we;
    assign cpu_dout   = ram_dout;
    assign hs_dout    = hs_dout_q;
    assign blocked_wr = blocked_q;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
module tb_hs_ram_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int SC  = 16;
    localparam int TMO = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [AW-1:0] cpu_addr = '0, hs_addr = '0, ram_addr;
    logic [DW-1:0] cpu_din = '0, hs_din = '0, cpu_dout, hs_dout, ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          cpu_we = 1'b0, hs_we = 1'b0, ir = 1'b0, iw = 1'b0;
    logic          pause_ack = 1'b0;
    logic          hs_grant, pause_req, ram_we, blocked_wr;
`ifdef HS_ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    hs_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_49m(clk), .reset(rst),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_dout(cpu_dout),
        .hs_addr(hs_addr), .hs_din(hs_din), .hs_we(hs_we),
        .hs_intent_read(ir), .hs_intent_write(iw),
        .hs_dout(hs_dout), .hs_grant(hs_grant),
        .pause_req(pause_req), .pause_ack(pause_ack),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
`ifdef HS_ARB_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .blocked_wr(blocked_wr)
    );

    // Shared RAM: 16 locations (low address bits), read data one cycle late.
    logic [DW-1:0] mem [0:15] = '{default: '0};
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr[3:0]];
        if (ram_we) mem[ram_addr[3:0]] <= ram_din;
    end

    // Next-cycle stimulus, applied just after each rising edge.
    logic          n_rst = 1'b1, n_ir = 1'b0, n_iw = 1'b0, n_cpu_we = 1'b0, n_hs_we = 1'b0;
    logic [AW-1:0] n_cpu_addr = '0, n_hs_addr = '0;
    logic [DW-1:0] n_cpu_din = '0, n_hs_din = '0;
    logic          ext_pause = 1'b0, err_drop = 1'b0, ack_force0 = 1'b0;

    // Reference model of the arbitration rules.
    bit            m_pend, m_grant, m_drain, m_gprev, m_blk;
    int            m_settle;          // cycles of settling still to go (0 = not settling)
    logic [DW-1:0] m_rdata = '0, m_hsdout = '0;
    logic [DW-1:0] refmem [0:15] = '{default: '0};
    logic [2:0]    pr_hist = '0;      // model pause_req history feeding the pause module
`ifdef HS_ARB_TIMEOUT_EN
    bit            m_terr;
    int            m_reqcyc;
    int            terr_cnt = 0;
`endif

    typedef struct {
        logic          pr, gr, we, blk, terr;
        logic [AW-1:0] addr;
        logic [DW-1:0] din, cdout, hdout;
    } exp_t;
    exp_t sbq[$];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, ack_rise_cyc = -1, grant_rise_cyc = -1;
    logic mon_gprev = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit            intent;
        bit            sel_hs;
        logic [3:0]    a;
        logic [DW-1:0] rd_new;
        intent = ir | iw;
        sel_hs = m_grant && !rst;
        a      = sel_hs ? hs_addr[3:0] : cpu_addr[3:0];
        rd_new = refmem[a];
        if (sel_hs ? hs_we : cpu_we) refmem[a] = sel_hs ? hs_din : cpu_din;
        pr_hist = {pr_hist[1:0], (!rst && (m_pend || m_settle > 0 || m_grant))};
        if (rst) begin
            m_pend = 0; m_grant = 0; m_drain = 0; m_settle = 0;
            m_gprev = 0; m_blk = 0; m_hsdout = '0; m_rdata = rd_new;
`ifdef HS_ARB_TIMEOUT_EN
            m_terr = 0; m_reqcyc = 0;
`endif
            return;
        end
`ifdef HS_ARB_TIMEOUT_EN
        m_terr = 0;
`endif
        if (m_gprev) m_hsdout = m_rdata;
        m_gprev = m_grant;
        if (m_grant && cpu_we) m_blk = 1;
        m_rdata = rd_new;
        if (m_drain) begin
            if (!pause_ack) m_drain = 0;
        end else if (m_grant) begin
            if (!intent || !pause_ack) begin m_grant = 0; m_drain = 1; end
        end else if (m_settle > 0) begin
            if (!intent || !pause_ack) begin m_settle = 0; m_drain = 1; end
            else if (m_settle == 1) begin m_settle = 0; m_grant = 1; end
            else m_settle--;
        end else if (m_pend) begin
            if (!intent) begin m_pend = 0; m_drain = 1; end
            else if (pause_ack) begin m_pend = 0; m_settle = SC; end
`ifdef HS_ARB_TIMEOUT_EN
            else if (m_reqcyc == TMO - 1) begin m_pend = 0; m_drain = 1; m_terr = 1; end
            else m_reqcyc++;
`endif
        end else if (intent) begin
            m_pend = 1;
`ifdef HS_ARB_TIMEOUT_EN
            m_reqcyc = 0;
`endif
        end
    endtask

    task automatic cycle();
        exp_t e;
        logic na;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        rst = n_rst; ir = n_ir; iw = n_iw;
        cpu_addr = n_cpu_addr; cpu_din = n_cpu_din; cpu_we = n_cpu_we;
        hs_addr = n_hs_addr; hs_din = n_hs_din; hs_we = n_hs_we;
        na = ack_force0 ? 1'b0 : ((pr_hist[2] | ext_pause) & ~err_drop);
        if (na && !pause_ack && ack_rise_cyc < 0) ack_rise_cyc = cyc;
        pause_ack = na;
        e.gr    = m_grant;
        e.pr    = m_pend || (m_settle > 0) || m_grant;
        e.addr  = m_grant ? hs_addr : cpu_addr;
        e.din   = m_grant ? hs_din  : cpu_din;
        e.we    = m_grant ? hs_we   : cpu_we;
        e.cdout = m_rdata;
        e.hdout = m_hsdout;
        e.blk   = m_blk;
`ifdef HS_ARB_TIMEOUT_EN
        e.terr  = m_terr;
`else
        e.terr  = 1'b0;
`endif
        sbq.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (hs_grant && !mon_gprev) grant_rise_cyc = cyc;
            mon_gprev = hs_grant;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pause_req", 32'(pause_req), 32'(e.pr));
                chk("hs_grant", 32'(hs_grant), 32'(e.gr));
                chk("ram_addr", 32'(ram_addr), 32'(e.addr));
                chk("ram_din", 32'(ram_din), 32'(e.din));
                chk("ram_we", 32'(ram_we), 32'(e.we));
                chk("cpu_dout", 32'(cpu_dout), 32'(e.cdout));
                chk("hs_dout", 32'(hs_dout), 32'(e.hdout));
                chk("blocked_wr", 32'(blocked_wr), 32'(e.blk));
`ifdef HS_ARB_TIMEOUT_EN
                chk("timeout_err", 32'(timeout_err), 32'(e.terr));
                if (timeout_err) terr_cnt++;
`endif
            end
        end
    end

    task automatic wait_grant(string tag);
        grant_rise_cyc = -1;
        for (int i = 0; i < 80 && grant_rise_cyc < 0; i++) cycle();
        n_tests++;
        if (grant_rise_cyc < 0) begin
            n_fail++;
            $display("FAIL %s: hs_grant never rose within 80 cycles, required a grant", tag);
        end
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Reset, then CPU owns the port.
        n_cpu_addr = 12'h100; n_cpu_din = 8'h11; n_cpu_we = 1'b1;
        n_hs_addr = 12'h0A0;
        run(3);
        n_rst = 1'b0;
        run(3);

        // Grant timing with pause_ack = pause_req delayed 3 cycles.
        n_cpu_we = 1'b0;
        ack_rise_cyc = -1;
        n_iw = 1'b1;
        wait_grant("grant1");
        chk("settle_latency", 32'(grant_rise_cyc - ack_rise_cyc), 32'(SC + 1));
        n_hs_din = 8'h5A; n_hs_we = 1'b1;
        run(1);
        n_hs_din = 8'hC3;
        run(1);
        n_hs_we = 1'b0; n_iw = 1'b0; n_ir = 1'b1;
        run(4);
        chk("hs_read_0A0", 32'(hs_dout), 32'h0C3);
        n_cpu_we = 1'b1;
        run(1);
        n_cpu_we = 1'b0; n_ir = 1'b0;
        run(12);

        // Second grant, then asynchronous reset in the middle of it.
        n_ir = 1'b1;
        wait_grant("grant2");
        run(2);
        @(negedge clk);
        #1;
        chk("pre_reset_grant", 32'(hs_grant), 32'd1);
        chk("pre_reset_blocked", 32'(blocked_wr), 32'd1);
        rst = 1'b1; n_rst = 1'b1;
        #1;
        chk("areset_grant", 32'(hs_grant), 32'd0);
        chk("areset_pause_req", 32'(pause_req), 32'd0);
        chk("areset_blocked", 32'(blocked_wr), 32'd0);
        chk("areset_mux", 32'(ram_addr), 32'h100);
        run(2);
        n_rst = 1'b0; n_ir = 1'b0;
        run(8);

        // Intent dropped while settling: no grant, no hiscore write.
        n_iw = 1'b1; n_hs_we = 1'b1; n_hs_din = 8'hEE;
        for (int i = 0; i < 40 && m_settle != 7; i++) cycle();
        n_iw = 1'b0;
        grant_rise_cyc = -1;
        run(10);
        chk("abort_no_grant", 32'(grant_rise_cyc), 32'hFFFF_FFFF);
        n_hs_we = 1'b0;

`ifdef HS_ARB_TIMEOUT_EN
        // Pause module never answers: a single timeout pulse, no grant.
        ack_force0 = 1'b1; terr_cnt = 0; grant_rise_cyc = -1;
        n_iw = 1'b1;
        run(110);
        n_iw = 1'b0;
        run(6);
        chk("timeout_pulses", 32'(terr_cnt), 32'd1);
        chk("timeout_no_grant", 32'(grant_rise_cyc), 32'hFFFF_FFFF);
        ack_force0 = 1'b0;
`endif

        // Randomized traffic, external pauses and protocol-error ack drops.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) begin
                if (n_ir || n_iw) begin n_ir = 1'b0; n_iw = 1'b0; end
                else {n_ir, n_iw} = 2'($urandom_range(3, 1));
            end
            n_cpu_addr = AW'($urandom); n_cpu_din = DW'($urandom);
            n_cpu_we   = ($urandom_range(3) == 0);
            n_hs_addr  = AW'($urandom); n_hs_din = DW'($urandom);
            n_hs_we    = ($urandom_range(2) == 0);
            if ($urandom_range(149) == 0) ext_pause = ~ext_pause;
            err_drop = ($urandom_range(99) == 0);
            cycle();
        end
        n_ir = 1'b0; n_iw = 1'b0; ext_pause = 1'b0; err_drop = 1'b0;
        run(4);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
